// File: rtl/if_pkg.sv
// Shared widths, the RISC-V NOP encoding and the prefetch-queue entry layout
// for the instruction-fetch front end.
package if_pkg;

  localparam int IF_ADDR_WIDTH  = 32;
  localparam int IF_INSTR_WIDTH = 32;

  // addi x0, x0, 0 -- bubble that decode can insert while id_valid is low
  localparam logic [IF_INSTR_WIDTH-1:0] IF_RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [IF_ADDR_WIDTH-1:0]  pc;
    logic [IF_INSTR_WIDTH-1:0] instr;
    logic                      filled;
  } fetch_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_ring.sv
// Prefetch ring storage: entries plus head/alloc/fill pointers, the
// allocated-entry level and the count of allocated-but-unfilled entries.
module fetch_ring
  import if_pkg::*;
#(
  parameter int ADDR_WIDTH  = IF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = IF_INSTR_WIDTH,
  parameter int DEPTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc_en,
  input  logic [ADDR_WIDTH-1:0]     alloc_pc,
  input  logic                      fill_en,
  input  logic [INSTR_WIDTH-1:0]    fill_instr,
  input  logic                      pop_en,
  output logic                      head_filled,
  output logic [ADDR_WIDTH-1:0]     head_pc,
  output logic [INSTR_WIDTH-1:0]    head_instr,
  output logic [ptr_width(DEPTH):0] level,
  output logic [ptr_width(DEPTH):0] pending
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   filled;
  } entry_t;

  entry_t           entries [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] alloc_ptr;
  logic [PTR_W-1:0] fill_ptr;

  assign head_filled = entries[head_ptr].filled;
  assign head_pc     = entries[head_ptr].pc;
  assign head_instr  = entries[head_ptr].instr;

  // Alloc, fill and pop never target the same slot: alloc writes a free
  // slot, fill the oldest unfilled one, pop only a filled head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      level     <= '0;
      pending   <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      level     <= '0;
      pending   <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].filled <= 1'b0;
    end else begin
      if (alloc_en) begin
        entries[alloc_ptr].pc     <= alloc_pc;
        entries[alloc_ptr].filled <= 1'b0;
        alloc_ptr                 <= alloc_ptr + 1'b1;
      end
      if (fill_en) begin
        entries[fill_ptr].instr  <= fill_instr;
        entries[fill_ptr].filled <= 1'b1;
        fill_ptr                 <= fill_ptr + 1'b1;
      end
      if (pop_en) begin
        entries[head_ptr].filled <= 1'b0;
        head_ptr                 <= head_ptr + 1'b1;
      end
      level   <= level + CNT_W'(alloc_en) - CNT_W'(pop_en);
      pending <= pending + CNT_W'(alloc_en) - CNT_W'(fill_en);
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Decoupled instruction-fetch front end: in-order req/gnt/rvalid fetches into
// a DEPTH-entry queue drained by decode over valid/ready; redirect flushes.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = IF_ADDR_WIDTH,
  parameter int                    INSTR_WIDTH = IF_INSTR_WIDTH,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req,
  output logic [ADDR_WIDTH-1:0]     imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [INSTR_WIDTH-1:0]    imem_rdata,
  input  logic                      redirect,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic                      id_valid,
  input  logic                      id_ready,
  output logic [ADDR_WIDTH-1:0]     id_pc,
  output logic [ADDR_WIDTH-1:0]     id_next_pc,
  output logic [INSTR_WIDTH-1:0]    id_instr,
  output logic [ptr_width(DEPTH):0] q_level
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Back-to-back redirects can stack stale responses beyond one ring's worth
  localparam int DROP_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [DROP_W-1:0]     drop_cnt;
  logic [CNT_W-1:0]      level;
  logic [CNT_W-1:0]      pending;
  logic                  head_filled;
  logic                  grant;
  logic                  fill;
  logic                  dropping;
  logic                  pop;
  logic                  unused_pc_lsbs;

  assign imem_req   = !rst && !redirect && (level < FULL);
  assign imem_addr  = fetch_pc;
  assign grant      = imem_req && imem_gnt;
  assign dropping   = imem_rvalid && (drop_cnt != '0);
  assign fill       = imem_rvalid && (drop_cnt == '0) && (pending != '0);
  assign id_valid   = head_filled && (level != '0) && !redirect;
  assign pop        = id_valid && id_ready;
  assign id_next_pc = id_pc + ADDR_WIDTH'(4);
  assign q_level    = level;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      // Every response still owed for an unfilled entry becomes stale
      drop_cnt <= drop_cnt + DROP_W'(pending) - DROP_W'(dropping || fill);
    end else begin
      if (grant)    fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      if (dropping) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  fetch_ring #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH),
    .DEPTH       (DEPTH)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect),
    .alloc_en    (grant),
    .alloc_pc    (fetch_pc),
    .fill_en     (fill),
    .fill_instr  (imem_rdata),
    .pop_en      (pop),
    .head_filled (head_filled),
    .head_pc     (id_pc),
    .head_instr  (id_instr),
    .level       (level),
    .pending     (pending)
  );

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (drop_cnt == '0) && (pending == '0)));

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with a queue-based reference model,
// an in-order variable-latency memory and hand-computed literal checks.
module tb_if_prefetch_unit;
  import if_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_next_pc;
  logic [31:0] id_instr;
  logic [2:0]  q_level;

  bit gnt_en;
  int lat;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  if_prefetch_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_next_pc  (id_next_pc),
    .id_instr    (id_instr),
    .q_level     (q_level)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return {addr[23:0], 8'h00} | IF_RV_NOP;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: the queue contents, the fetch PC and the stale count
  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  ent_t        mq[$];
  mreq_t       memq[$];
  logic [31:0] m_fetch_pc;
  int          m_drop;
  int          cyc;
  bit          done;
  bit          exp_req, exp_valid;
  bit          s_redirect, s_fire, s_rvalid, s_pop;
  logic [31:0] s_rpc, s_rdata;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      mq.delete(); memq.delete();
      m_fetch_pc = 32'h0; m_drop = 0; cyc = 0;
      s_redirect = 0; s_fire = 0; s_rvalid = 0; s_pop = 0;
      imem_gnt = gnt_en; imem_rvalid = 1'b0;
    end else begin
      cyc++;
      if (s_rvalid) begin
        if (m_drop > 0) m_drop--;
        else begin
          done = 0;
          foreach (mq[i]) if (!done && !mq[i].filled) begin
            mq[i].instr = s_rdata; mq[i].filled = 1; done = 1;
          end
        end
      end
      if (s_redirect) begin
        foreach (mq[i]) if (!mq[i].filled) m_drop++;
        mq.delete();
        m_fetch_pc = s_rpc & ~32'h3;
      end else begin
        if (s_pop) void'(mq.pop_front());
        if (s_fire) begin
          mq.push_back('{pc: m_fetch_pc, instr: 32'h0, filled: 1'b0});
          memq.push_back('{addr: m_fetch_pc, due: cyc + lat});
          m_fetch_pc += 32'd4;
        end
      end
      imem_gnt = gnt_en;
      if (memq.size() > 0 && memq[0].due <= cyc + 1) begin
        imem_rvalid = 1'b1; imem_rdata = instr_of(memq[0].addr); void'(memq.pop_front());
      end else begin
        imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      end
      #1;
      exp_req   = !redirect && mq.size() < DEPTH;
      exp_valid = !redirect && mq.size() > 0 && mq[0].filled;
      chk("m_imem_req", imem_req, exp_req);
      chk("m_imem_addr", imem_addr, m_fetch_pc);
      chk("m_q_level", q_level, mq.size());
      chk("m_id_valid", id_valid, exp_valid);
      if (exp_valid) begin
        chk("m_id_pc", id_pc, mq[0].pc);
        chk("m_id_next_pc", id_next_pc, mq[0].pc + 32'd4);
        chk("m_id_instr", id_instr, mq[0].instr);
      end
      s_redirect = redirect; s_rpc = redirect_pc;
      s_fire = exp_req && imem_gnt;
      s_rvalid = imem_rvalid; s_rdata = imem_rdata;
      s_pop = exp_valid && id_ready;
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      #3;
      if (id_valid) begin ok = 1; break; end
      nxt();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int grants;
    rst = 1; redirect = 0; redirect_pc = 0; id_ready = 1; gnt_en = 1; lat = 1;
    repeat (2) nxt();
    #3;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_next_pc", id_next_pc, 32'h4);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_q_level", q_level, 0);
    nxt();
    rst = 0;

    // Streaming: gnt=1, latency 1, ready=1
    for (int k = 0; k < 6; k++) begin
      #3;
      chk("stream_req", imem_req, 1);
      chk("stream_addr", imem_addr, 32'(4 * k));
      chk("stream_valid", id_valid, k >= 2);
      if (k >= 2) begin
        chk("stream_pc", id_pc, 32'(4 * (k - 2)));
        chk("stream_next_pc", id_next_pc, 32'(4 * (k - 1)));
        chk("stream_instr", id_instr, instr_of(32'(4 * (k - 2))));
      end
      nxt();
    end

    // Fill to full with decode stalled, then release
    id_ready = 0; redirect = 1; redirect_pc = 32'h0;
    nxt();
    redirect = 0; grants = 0;
    for (int k = 0; k < 8; k++) begin
      #3;
      if (imem_req && imem_gnt) begin
        chk("full_grant_addr", imem_addr, 32'(4 * grants));
        grants++;
      end
      nxt();
    end
    chk("full_grant_count", 32'(grants), 32'd4);
    id_ready = 1;
    #3;
    chk("full_q_level", q_level, 4);
    chk("full_req", imem_req, 0);
    chk("full_pop_valid", id_valid, 1);
    chk("full_pop_pc", id_pc, 32'h0);
    nxt();
    #3;
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 32'h10);
    chk("resume_pc", id_pc, 32'h4);
    nxt();

    // Redirect with three fetches outstanding
    lat = 4; gnt_en = 0; redirect = 1; redirect_pc = 32'h40;
    nxt();
    redirect = 0;
    repeat (8) nxt();
    gnt_en = 1;
    repeat (3) nxt();
    gnt_en = 0; redirect = 1; redirect_pc = 32'h101;
    #3;
    chk("redir_req_low", imem_req, 0);
    chk("redir_valid_low", id_valid, 0);
    nxt();
    redirect = 0; gnt_en = 1;
    #3;
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_req", imem_req, 1);
    nxt();
    wait_valid(ok);
    chk("redir_wait", 32'(ok), 32'd1);
    chk("redir_first_pc", id_pc, 32'h100);
    chk("redir_first_instr", id_instr, instr_of(32'h100));
    nxt();

    // Redirect coinciding with a response, two outstanding
    lat = 3; gnt_en = 0; redirect = 1; redirect_pc = 32'h200;
    nxt();
    redirect = 0;
    repeat (8) nxt();
    gnt_en = 1;
    repeat (2) nxt();
    gnt_en = 0;
    nxt();
    redirect = 1; redirect_pc = 32'h100;
    nxt();
    redirect = 0; gnt_en = 1;
    wait_valid(ok);
    chk("coinc_wait", 32'(ok), 32'd1);
    chk("coinc_pc", id_pc, 32'h100);
    chk("coinc_instr", id_instr, instr_of(32'h100));
    nxt();

    // Grant withheld: address must hold
    gnt_en = 0; redirect = 1; redirect_pc = 32'h20;
    nxt();
    redirect = 0;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk("hold_addr", imem_addr, 32'h20);
      nxt();
    end
    gnt_en = 1;
    #3;
    chk("hold_q_level", q_level, 0);
    chk("hold_req", imem_req, 1);
    nxt();
    gnt_en = 0;
    #3;
    chk("hold_after_addr", imem_addr, 32'h24);
    chk("hold_after_level", q_level, 1);
    nxt();

    // Address wrap-around
    lat = 1; gnt_en = 1; redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    nxt();
    redirect = 0;
    #3;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    nxt();
    #3;
    chk("wrap_addr1", imem_addr, 32'h0);
    nxt();
    wait_valid(ok);
    chk("wrap_wait", 32'(ok), 32'd1);
    chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_next_pc", id_next_pc, 32'h0);
    nxt();

    repeat (10) nxt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
